obj_oam_writer: RTL and testbench

- CPU-side write/read port and storage for the 1 KB object attribute memory (OAM), organised as 256 x 32 bits.
- Serves the object lookup unit's read interface: word address OAMaddr in, OAMdata out one cycle later.
- Accepts CPU halfword and word accesses. Buffers CPU writes in a small FIFO while the renderer owns OAM, then drains them when the renderer is idle.

---
 rtl/obj_pkg.sv | 18 +
 rtl/obj_oam_fifo.sv | 48 ++++
 rtl/obj_oam_writer.sv | 98 +++++++++
 tb/tb_obj_oam_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - shared types and constants for the object attribute memory writer
package obj_pkg;

    localparam int OAM_WORDS = 256;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } cpu_size_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } oam_wr_t;

endpackage

// File: rtl/obj_oam_fifo.sv
// rtl/obj_oam_fifo.sv - pending CPU write queue; pointers carry one wrap bit for full/empty
module obj_oam_fifo
    import obj_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  oam_wr_t push_data,
    input  logic    pop,
    output oam_wr_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    oam_wr_t     q [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = q[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            q[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/obj_oam_writer.sv
// rtl/obj_oam_writer.sv - OAM storage with buffered CPU writes; OBJ_OAM_BYTE_WRITE_EN enables byte writes
module obj_oam_writer
    import obj_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  OAMaddr,
    output logic [31:0] OAMdata,
    input  logic        obj_busy,
    input  logic [9:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        fifo_empty
);

    logic [31:0] mem [OAM_WORDS];

    oam_wr_t wr_ent;
    oam_wr_t drain_ent;
    logic    push_ok;
    logic    fifo_full;
    logic    push;
    logic    pop;
    logic    rd_fire;

    always_comb begin
        wr_ent.addr = cpu_addr[9:2];
        wr_ent.data = cpu_wdata;
        wr_ent.be   = 4'b1111;
        push_ok     = 1'b1;
        case (cpu_size_t'(cpu_size))
            SZ_BYTE: begin
`ifdef OBJ_OAM_BYTE_WRITE_EN
                wr_ent.be   = 4'b0001 << cpu_addr[1:0];
                wr_ent.data = {4{cpu_wdata[{cpu_addr[1:0], 3'b000} +: 8]}};
`else
                push_ok     = 1'b0;
`endif
            end
            SZ_HALF: wr_ent.be = cpu_addr[1] ? 4'b1100 : 4'b0011;
            default: wr_ent.be = 4'b1111;
        endcase
    end

    // Reads wait for an idle renderer and an empty queue so they observe every earlier write.
    assign rd_fire   = cpu_rd && !obj_busy && fifo_empty;
    assign push      = cpu_wr && !fifo_full && push_ok;
    assign pop       = !obj_busy && !fifo_empty;
    assign cpu_ready = (cpu_wr && !fifo_full) || rd_fire;

    logic unused_addr_bit;
    assign unused_addr_bit = cpu_addr[0];

    obj_oam_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (wr_ent),
        .pop       (pop),
        .pop_data  (drain_ent),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (pop) begin
            for (int i = 0; i < 4; i++) begin
                if (drain_ent.be[i]) begin
                    mem[drain_ent.addr][i*8 +: 8] <= drain_ent.data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            OAMdata    <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            OAMdata    <= mem[OAMaddr];
            cpu_rvalid <= rd_fire;
            if (rd_fire) begin
                cpu_rdata <= mem[cpu_addr[9:2]];
            end
        end
    end

endmodule

// File: tb/tb_obj_oam_writer.sv
// tb/tb_obj_oam_writer.sv - scoreboard bench for obj_oam_writer
module tb_obj_oam_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  OAMaddr = '0;
    logic [31:0] OAMdata;
    logic        obj_busy = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        fifo_empty;

    int errors = 0;
    int checks = 0;

    logic [31:0] oam_q [$];
    logic [31:0] rd_q [$];
    logic        oam_req = 1'b0;
    logic        oam_pend = 1'b0;

    always #5 clock = ~clock;

    obj_oam_writer #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .OAMaddr    (OAMaddr),
        .OAMdata    (OAMdata),
        .obj_busy   (obj_busy),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_size   (cpu_size),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .fifo_empty (fifo_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clock) oam_pend <= oam_req;

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clock) begin
        if (oam_pend) begin
            if (oam_q.size() == 0) begin
                check("oam_queue_underflow", 32'd1, 32'd0);
            end else begin
                check("oam_data", OAMdata, oam_q.pop_front());
            end
        end
        if (cpu_rvalid) begin
            if (rd_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                check("cpu_rdata", cpu_rdata, rd_q.pop_front());
            end
        end
    end

    task automatic oam_read(input logic [7:0] a, input logic [31:0] exp);
        @(negedge clock);
        OAMaddr = a;
        oam_req = 1'b1;
        oam_q.push_back(exp);
        @(negedge clock);
        oam_req = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        #1;
        while (!cpu_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!cpu_ready) check(name, 32'd0, 32'd1);
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clock);
        cpu_addr = a; cpu_wdata = d; cpu_size = sz; cpu_wr = 1'b1;
        wait_ready("write_ready_timeout");
        @(posedge clock);
        #1 cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [9:0] a, input logic [31:0] exp);
        @(negedge clock);
        cpu_addr = a; cpu_size = 2'd2; cpu_rd = 1'b1;
        rd_q.push_back(exp);
        wait_ready("read_ready_timeout");
        @(posedge clock);
        #1 cpu_rd = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!fifo_empty && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("drain_empty", {31'd0, fifo_empty}, 32'd1);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_oamdata", OAMdata, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // 1: word write then renderer read
        cpu_write(10'h004, 32'hDEADBEEF, 2'd2);
        @(negedge clock);
        @(negedge clock);
        check("t1_empty", {31'd0, fifo_empty}, 32'd1);
        oam_read(8'd1, 32'hDEADBEEF);

        // 2: halfword merge into upper lanes
        cpu_write(10'h008, 32'hAAAAAAAA, 2'd2);
        cpu_write(10'h00A, 32'h12340000, 2'd1);
        wait_empty();
        oam_read(8'd2, 32'h1234AAAA);
        cpu_read(10'h008, 32'h1234AAAA);

        // 3: fill the queue while the renderer is busy
        @(negedge clock);
        obj_busy = 1'b1;
        for (int i = 0; i < 4; i++) cpu_write(10'h040 + 10'(i * 4), 32'hA0000000 + 32'(i), 2'd2);
        @(negedge clock);
        cpu_addr = 10'h050; cpu_wdata = 32'hA0000004; cpu_size = 2'd2; cpu_wr = 1'b1;
        #1;
        check("t3_full_stall", {31'd0, cpu_ready}, 32'd0);
        check("t3_not_empty", {31'd0, fifo_empty}, 32'd0);
        @(negedge clock);
        #1;
        check("t3_still_stalled", {31'd0, cpu_ready}, 32'd0);
        @(negedge clock);
        obj_busy = 1'b0;
        wait_ready("t3_fifth_timeout");
        @(posedge clock);
        #1 cpu_wr = 1'b0;
        wait_empty();
        oam_read(8'd16, 32'hA0000000);
        oam_read(8'd19, 32'hA0000003);
        oam_read(8'd20, 32'hA0000004);

        // 4: byte write
        cpu_write(10'h010, 32'h11223344, 2'd2);
        cpu_write(10'h010, 32'h000000FF, 2'd0);
        wait_empty();
`ifdef OBJ_OAM_BYTE_WRITE_EN
        oam_read(8'd4, 32'h112233FF);
`else
        oam_read(8'd4, 32'h11223344);
`endif

        // 5: read ordered behind a queued write
        @(negedge clock);
        obj_busy = 1'b1;
        cpu_write(10'h01C, 32'hC0FFEE07, 2'd2);
        @(negedge clock);
        cpu_addr = 10'h01C; cpu_size = 2'd2; cpu_rd = 1'b1;
        rd_q.push_back(32'hC0FFEE07);
        #1;
        check("t5_read_stall", {31'd0, cpu_ready}, 32'd0);
        @(negedge clock);
        obj_busy = 1'b0;
        wait_ready("t5_read_timeout");
        @(posedge clock);
        #1 cpu_rd = 1'b0;

        // 6: reset mid-drain
        cpu_write(10'h060, 32'h11111111, 2'd2);
        cpu_write(10'h064, 32'h22222222, 2'd2);
        cpu_write(10'h068, 32'h33333333, 2'd2);
        wait_empty();
        @(negedge clock);
        obj_busy = 1'b1;
        cpu_write(10'h060, 32'h44444444, 2'd2);
        cpu_write(10'h064, 32'h55555555, 2'd2);
        cpu_write(10'h068, 32'h66666666, 2'd2);
        @(negedge clock);
        obj_busy = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_empty", {31'd0, fifo_empty}, 32'd1);
        check("t6_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        oam_read(8'd24, 32'h44444444);
        oam_read(8'd25, 32'h22222222);
        oam_read(8'd26, 32'h33333333);

        repeat (4) @(negedge clock);
        check("oam_q_left", oam_q.size(), 32'd0);
        check("rd_q_left", rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
